// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the set-associative L1 data cache.
// Holds the controller state encoding, geometry derivations and the byte-merge used by stores.
package l1_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WB_REQ     = 3'd1,
        S_WB_WAIT    = 3'd2,
        S_FILL_REQ   = 3'd3,
        S_FILL_WAIT  = 3'd4,
        S_FLUSH_SCAN = 3'd5,
        S_FLUSH_WB   = 3'd6,
        S_FLUSH_WAIT = 3'd7
    } state_e;

    // Widest core word the merge helper handles; callers cast in and out.
    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic int calc_tag_bits(input int addr_w, input int index_bits, input int line_bits);
        return addr_w - index_bits - line_bits;
    endfunction

    function automatic int calc_words(input int line_bits, input int data_w);
        return (8 << line_bits) / data_w;
    endfunction

    function automatic logic [MERGE_W-1:0] merge_bytes(input logic [MERGE_W-1:0]    old_w,
                                                       input logic [MERGE_W-1:0]    new_w,
                                                       input logic [MERGE_BE_W-1:0] be);
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/l1_cache_assoc_way.sv
// One way of the cache: tag and line storage, synchronous write, combinational read.
// Arrays are intentionally unreset; the valid bits in the controller qualify their contents.
module l1_way_array #(
    parameter int TAG_BITS   = 20,
    parameter int INDEX_BITS = 7,
    parameter int LINE_W     = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] w_idx,
    input  logic [TAG_BITS-1:0]   w_tag,
    input  logic [LINE_W-1:0]     w_line,
    input  logic [INDEX_BITS-1:0] r_idx,
    output logic [TAG_BITS-1:0]   r_tag,
    output logic [LINE_W-1:0]     r_line
);

    logic [TAG_BITS-1:0] tag_mem  [1<<INDEX_BITS];
    logic [LINE_W-1:0]   data_mem [1<<INDEX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[w_idx]  <= w_tag;
            data_mem[w_idx] <= w_line;
        end
    end

    assign r_tag  = tag_mem[r_idx];
    assign r_line = data_mem[r_idx];

endmodule

// File: rtl/l1_cache_assoc.sv
// N-way set-associative write-back, write-allocate L1 data cache with one outstanding miss,
// per-set round-robin replacement and a whole-cache flush walk.
module l1_cache_assoc
    import l1_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BITS  = 5,
    parameter int INDEX_BITS = 7,
    parameter int WAYS       = 2,
    parameter int ID_BITS    = 4,
    localparam int WORDS     = calc_words(LINE_BITS, DATA_WIDTH),
    localparam int TAG_BITS  = calc_tag_bits(ADDR_WIDTH, INDEX_BITS, LINE_BITS),
    localparam int LINE_W    = DATA_WIDTH * WORDS,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  rw_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [BE_W-1:0]       be_in,
    input  logic [ID_BITS-1:0]    id_in,
    output logic                  stall_out,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ID_BITS-1:0]    id_out,
    input  logic                  flush_in,
    output logic                  flush_done_out,
    output logic                  l2_valid_o,
    output logic                  l2_rw_o,
    output logic [ADDR_WIDTH-1:0] l2_addr_o,
    output logic [LINE_W-1:0]     l2_data_o,
    input  logic                  l2_stall_i,
    input  logic                  l2_valid_i,
    input  logic [LINE_W-1:0]     l2_data_i,
    output logic [2:0]            state_dbg_o
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int BOFF     = $clog2(BE_W);
    localparam int WSEL     = LINE_BITS - BOFF;
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e state_q, state_d;
    logic [WAYS-1:0]     valid_q [SETS], valid_d [SETS];
    logic [WAYS-1:0]     dirty_q [SETS], dirty_d [SETS];
    logic [WAY_BITS-1:0] rr_q    [SETS], rr_d    [SETS];

    logic                  req_rw_q, req_rw_d;
    logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
    logic [INDEX_BITS-1:0] req_idx_q, req_idx_d;
    logic [WSEL-1:0]       req_word_q, req_word_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [BE_W-1:0]       req_be_q, req_be_d;
    logic [ID_BITS-1:0]    req_id_q, req_id_d;
    logic [WAY_BITS-1:0]   victim_q, victim_d;
    logic                  had_inv_q, had_inv_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ID_BITS-1:0]    id_out_q, id_out_d;
    logic                  flush_done_q, flush_done_d;
    logic [INDEX_BITS-1:0] scan_idx_q, scan_idx_d;
    logic [WAY_BITS-1:0]   scan_way_q, scan_way_d;

    logic [TAG_BITS-1:0]   in_tag;
    logic [INDEX_BITS-1:0] in_idx;
    logic [WSEL-1:0]       in_word;
    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag  [WAYS];
    logic [LINE_W-1:0]     rd_line [WAYS];
    logic [WAYS-1:0]       way_we;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [LINE_W-1:0]     w_line;

    logic                  hit_any, any_inv, flush_step;
    logic [WAY_BITS-1:0]   hit_way, vic_way;

    assign in_tag  = addr_in[ADDR_WIDTH-1 -: TAG_BITS];
    assign in_idx  = addr_in[LINE_BITS +: INDEX_BITS];
    assign in_word = addr_in[BOFF +: WSEL];

    // The single read port follows whichever set the current state is working on.
    always_comb begin
        rd_idx = req_idx_q;
        if (state_q == S_IDLE) rd_idx = in_idx;
        else if (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB || state_q == S_FLUSH_WAIT)
            rd_idx = scan_idx_q;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        l1_way_array #(
            .TAG_BITS   (TAG_BITS),
            .INDEX_BITS (INDEX_BITS),
            .LINE_W     (LINE_W)
        ) u_way (
            .clk    (clk),
            .we     (way_we[g]),
            .w_idx  (w_idx),
            .w_tag  (w_tag),
            .w_line (w_line),
            .r_idx  (rd_idx),
            .r_tag  (rd_tag[g]),
            .r_line (rd_line[g])
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_q[in_idx][w] && rd_tag[w] == in_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        any_inv = 1'b0;
        vic_way = rr_q[in_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[in_idx][w]) begin
                any_inv = 1'b1;
                vic_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        rr_d         = rr_q;
        req_rw_d     = req_rw_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_word_d   = req_word_q;
        req_data_d   = req_data_q;
        req_be_d     = req_be_q;
        req_id_d     = req_id_q;
        victim_d     = victim_q;
        had_inv_d    = had_inv_q;
        ready_d      = 1'b0;
        data_out_d   = data_out_q;
        id_out_d     = id_out_q;
        flush_done_d = 1'b0;
        scan_idx_d   = scan_idx_q;
        scan_way_d   = scan_way_q;
        way_we       = '0;
        w_idx        = req_idx_q;
        w_tag        = req_tag_q;
        w_line       = '0;
        flush_step   = 1'b0;
        l2_valid_o   = 1'b0;
        l2_rw_o      = 1'b0;
        l2_addr_o    = '0;
        l2_data_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (flush_in) begin
                    state_d    = S_FLUSH_SCAN;
                    scan_idx_d = '0;
                    scan_way_d = '0;
                end else if (valid_in) begin
                    if (hit_any) begin
                        if (rw_in) begin
                            w_line = rd_line[hit_way];
                            w_line[int'(in_word)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(merge_bytes(
                                MERGE_W'(w_line[int'(in_word)*DATA_WIDTH +: DATA_WIDTH]),
                                MERGE_W'(data_in), MERGE_BE_W'(be_in)));
                            way_we[hit_way]          = 1'b1;
                            w_idx                    = in_idx;
                            w_tag                    = in_tag;
                            dirty_d[in_idx][hit_way] = 1'b1;
                        end else begin
                            ready_d    = 1'b1;
                            data_out_d = rd_line[hit_way][int'(in_word)*DATA_WIDTH +: DATA_WIDTH];
                            id_out_d   = id_in;
                        end
                    end else begin
                        req_rw_d   = rw_in;
                        req_tag_d  = in_tag;
                        req_idx_d  = in_idx;
                        req_word_d = in_word;
                        req_data_d = data_in;
                        req_be_d   = be_in;
                        req_id_d   = id_in;
                        victim_d   = vic_way;
                        had_inv_d  = any_inv;
                        if (valid_q[in_idx][vic_way] && dirty_q[in_idx][vic_way]) state_d = S_WB_REQ;
                        else state_d = S_FILL_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                l2_valid_o = 1'b1;
                l2_rw_o    = 1'b1;
                l2_addr_o  = {rd_tag[victim_q], req_idx_q, {LINE_BITS{1'b0}}};
                l2_data_o  = rd_line[victim_q];
                if (!l2_stall_i) state_d = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (l2_valid_i) state_d = S_FILL_REQ;
            end
            S_FILL_REQ: begin
                l2_valid_o = 1'b1;
                l2_addr_o  = {req_tag_q, req_idx_q, {LINE_BITS{1'b0}}};
                if (!l2_stall_i) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (l2_valid_i) begin
                    w_line = l2_data_i;
                    if (req_rw_q) begin
                        w_line[int'(req_word_q)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(merge_bytes(
                            MERGE_W'(l2_data_i[int'(req_word_q)*DATA_WIDTH +: DATA_WIDTH]),
                            MERGE_W'(req_data_q), MERGE_BE_W'(req_be_q)));
                    end else begin
                        ready_d    = 1'b1;
                        data_out_d = l2_data_i[int'(req_word_q)*DATA_WIDTH +: DATA_WIDTH];
                        id_out_d   = req_id_q;
                    end
                    way_we[victim_q]              = 1'b1;
                    valid_d[req_idx_q][victim_q]  = 1'b1;
                    dirty_d[req_idx_q][victim_q]  = req_rw_q;
                    // Filling an empty way leaves the rotation where it was.
                    if (!had_inv_q) begin
                        rr_d[req_idx_q] = (rr_q[req_idx_q] == WAY_BITS'(WAYS - 1)) ? '0
                                        : rr_q[req_idx_q] + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                if (valid_q[scan_idx_q][scan_way_q] && dirty_q[scan_idx_q][scan_way_q])
                    state_d = S_FLUSH_WB;
                else
                    flush_step = 1'b1;
            end
            S_FLUSH_WB: begin
                l2_valid_o = 1'b1;
                l2_rw_o    = 1'b1;
                l2_addr_o  = {rd_tag[scan_way_q], scan_idx_q, {LINE_BITS{1'b0}}};
                l2_data_o  = rd_line[scan_way_q];
                if (!l2_stall_i) state_d = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                if (l2_valid_i) flush_step = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_step) begin
            valid_d[scan_idx_q][scan_way_q] = 1'b0;
            dirty_d[scan_idx_q][scan_way_q] = 1'b0;
            if (scan_idx_q == INDEX_BITS'(SETS - 1) && scan_way_q == WAY_BITS'(WAYS - 1)) begin
                flush_done_d = 1'b1;
                state_d      = S_IDLE;
            end else begin
                state_d = S_FLUSH_SCAN;
                if (scan_way_q == WAY_BITS'(WAYS - 1)) begin
                    scan_way_d = '0;
                    scan_idx_d = scan_idx_q + 1'b1;
                end else begin
                    scan_way_d = scan_way_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '{default: '0};
            dirty_q      <= '{default: '0};
            rr_q         <= '{default: '0};
            req_rw_q     <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_word_q   <= '0;
            req_data_q   <= '0;
            req_be_q     <= '0;
            req_id_q     <= '0;
            victim_q     <= '0;
            had_inv_q    <= 1'b0;
            ready_q      <= 1'b0;
            data_out_q   <= '0;
            id_out_q     <= '0;
            flush_done_q <= 1'b0;
            scan_idx_q   <= '0;
            scan_way_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
            req_rw_q     <= req_rw_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            req_word_q   <= req_word_d;
            req_data_q   <= req_data_d;
            req_be_q     <= req_be_d;
            req_id_q     <= req_id_d;
            victim_q     <= victim_d;
            had_inv_q    <= had_inv_d;
            ready_q      <= ready_d;
            data_out_q   <= data_out_d;
            id_out_q     <= id_out_d;
            flush_done_q <= flush_done_d;
            scan_idx_q   <= scan_idx_d;
            scan_way_q   <= scan_way_d;
        end
    end

    assign stall_out      = (state_q != S_IDLE) | flush_in;
    assign ready_out      = ready_q;
    assign data_out       = data_out_q;
    assign id_out         = id_out_q;
    assign flush_done_out = flush_done_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_l1_cache_assoc.sv
// Directed bench for l1_cache_assoc: load responses are checked by a queue-based monitor,
// L2 traffic is played by driver tasks that check each request as it appears.
module tb_l1_cache_assoc;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in, rw_in, flush_in;
  logic [31:0]  addr_in, data_in;
  logic [3:0]   be_in, id_in;
  logic         stall_out, ready_out, flush_done_out;
  logic [31:0]  data_out;
  logic [3:0]   id_out;
  logic         l2_valid_o, l2_rw_o, l2_stall_i, l2_valid_i;
  logic [31:0]  l2_addr_o;
  logic [255:0] l2_data_o, l2_data_i;
  logic [2:0]   state_dbg_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  l1_cache_assoc dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .rw_in(rw_in), .addr_in(addr_in),
    .data_in(data_in), .be_in(be_in), .id_in(id_in), .stall_out(stall_out),
    .ready_out(ready_out), .data_out(data_out), .id_out(id_out), .flush_in(flush_in),
    .flush_done_out(flush_done_out), .l2_valid_o(l2_valid_o), .l2_rw_o(l2_rw_o),
    .l2_addr_o(l2_addr_o), .l2_data_o(l2_data_o), .l2_stall_i(l2_stall_i),
    .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i), .state_dbg_o(state_dbg_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'(base + 8'(i));
    return l;
  endfunction

  // monitor: every registered load response must match the head of the expected queue
  initial begin
    logic [35:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (ready_out === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL load_resp: got unexpected data=%h id=%h, required no response", data_out, id_out);
        end else begin
          e = exp_q.pop_front();
          if ({id_out, data_out} !== e) begin
            n_err++;
            $display("FAIL load_resp: got id=%h data=%h, required id=%h data=%h",
                     id_out, data_out, e[35:32], e[31:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [3:0] id);
    valid_in = 1'b1; rw_in = rw; addr_in = addr; data_in = data; be_in = be; id_in = id;
    #1;
    check("accept", {63'd0, stall_out}, 64'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0; rw_in = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] exp_data);
    exp_q.push_back({id, exp_data});
    issue(1'b0, addr, 32'd0, 4'd0, id);
  endtask

  task automatic wait_l2(output bit found);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (l2_valid_o) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic l2_fill(input string name, input logic [31:0] exp_addr, input logic [7:0] base);
    bit f;
    wait_l2(f);
    check({name, "_req_seen"}, {63'd0, f}, 64'd1);
    if (!f) return;
    check({name, "_rd_rw"}, {63'd0, l2_rw_o}, 64'd0);
    check({name, "_rd_addr"}, {32'd0, l2_addr_o}, {32'd0, exp_addr});
    tick();
    l2_valid_i = 1'b1;
    l2_data_i  = make_line(base);
    tick();
    l2_valid_i = 1'b0;
    l2_data_i  = '0;
    check({name, "_stall_after_fill"}, {63'd0, stall_out}, 64'd0);
  endtask

  task automatic l2_wb(input string name, input logic [31:0] exp_addr, input int word,
                       input logic [31:0] exp_word);
    bit f;
    wait_l2(f);
    check({name, "_req_seen"}, {63'd0, f}, 64'd1);
    if (!f) return;
    check({name, "_wb_rw"}, {63'd0, l2_rw_o}, 64'd1);
    check({name, "_wb_addr"}, {32'd0, l2_addr_o}, {32'd0, exp_addr});
    check({name, "_wb_word"}, {32'd0, l2_data_o[word*32 +: 32]}, {32'd0, exp_word});
    tick();
    l2_valid_i = 1'b1;
    tick();
    l2_valid_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_stall"}, {63'd0, stall_out}, 64'd0);
    check({name, "_ready"}, {63'd0, ready_out}, 64'd0);
    check({name, "_data"}, {32'd0, data_out}, 64'd0);
    check({name, "_id"}, {60'd0, id_out}, 64'd0);
    check({name, "_flush_done"}, {63'd0, flush_done_out}, 64'd0);
    check({name, "_l2_valid"}, {63'd0, l2_valid_o}, 64'd0);
    check({name, "_l2_rw"}, {63'd0, l2_rw_o}, 64'd0);
    check({name, "_l2_addr"}, {32'd0, l2_addr_o}, 64'd0);
    check({name, "_l2_data_zero"}, {63'd0, (l2_data_o == '0)}, 64'd1);
  endtask

  initial begin
    bit done;
    int extra;
    reset = 1'b1; valid_in = 1'b0; rw_in = 1'b0; flush_in = 1'b0;
    addr_in = '0; data_in = '0; be_in = '0; id_in = '0;
    l2_stall_i = 1'b0; l2_valid_i = 1'b0; l2_data_i = '0;
    repeat (3) tick();
    check_outputs_zero("in_reset");
    reset = 1'b0;
    tick();
    check_outputs_zero("after_reset");
    check("after_reset_state", {61'd0, state_dbg_o}, 64'd0);

    // cold load: read request one cycle after acceptance, word1 of the fill returned
    load(32'h1004, 4'd1, 32'h0000_00A1);
    check("cold_l2_valid_n1", {63'd0, l2_valid_o}, 64'd1);
    l2_fill("cold", 32'h1000, 8'hA0);
    check("cold_ready_m1", {63'd0, ready_out}, 64'd1);
    load(32'h1004, 4'd2, 32'h0000_00A1);
    check("reload_no_l2", {63'd0, l2_valid_o}, 64'd0);
    check("reload_ready_n1", {63'd0, ready_out}, 64'd1);

    // partial store then load of the merged word
    issue(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'b0011, 4'd3);
    check("store_no_ready", {63'd0, ready_out}, 64'd0);
    load(32'h1008, 4'd4, 32'h0000_BEEF);

    // fill the empty way, then evict the dirty way0 ahead of the next read
    load(32'h2000, 4'd5, 32'h0000_00B0);
    l2_fill("fill_2000", 32'h2000, 8'hB0);
    load(32'h3000, 4'd6, 32'h0000_00C0);
    l2_wb("evict_1000", 32'h1000, 2, 32'h0000_BEEF);
    l2_fill("fill_3000", 32'h3000, 8'hC0);

    // back-to-back hits in both ways
    load(32'h2004, 4'd7, 32'h0000_00B1);
    load(32'h300C, 4'd8, 32'h0000_00C3);

    // backpressure: the fill request must hold while the L2 stalls
    l2_stall_i = 1'b1;
    load(32'h4004, 4'd9, 32'h0000_00D1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, l2_valid_o}, 64'd1);
      check("bp_addr", {32'd0, l2_addr_o}, 64'h4000);
      check("bp_state", {61'd0, state_dbg_o}, 64'd3);
      tick();
    end
    l2_stall_i = 1'b0;
    l2_fill("fill_4000", 32'h4000, 8'hD0);

    // two dirty lines: store hit at 0x3000, store miss at 0x5020
    issue(1'b1, 32'h3000, 32'h1122_3344, 4'b1111, 4'd10);
    issue(1'b1, 32'h5020, 32'h5566_7788, 4'b1111, 4'd11);
    l2_fill("fill_5020", 32'h5020, 8'hE0);
    check("store_miss_no_ready", {63'd0, ready_out}, 64'd0);

    // flush has priority over a same-cycle request
    flush_in = 1'b1;
    valid_in = 1'b1; rw_in = 1'b0; addr_in = 32'h3000; id_in = 4'd12;
    #1;
    check("flush_stall", {63'd0, stall_out}, 64'd1);
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    l2_wb("flush_wb0", 32'h3000, 0, 32'h1122_3344);
    l2_wb("flush_wb1", 32'h5020, 0, 32'h5566_7788);
    done = 1'b0;
    extra = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (flush_done_out) done = 1'b1;
      else begin
        if (l2_valid_o) extra++;
        tick();
      end
    end
    check("flush_done_seen", {63'd0, done}, 64'd1);
    check("flush_extra_l2", 64'(extra), 64'd0);
    tick();
    check("flush_done_pulse", {63'd0, flush_done_out}, 64'd0);

    // flushed lines miss
    load(32'h3000, 4'd13, 32'h0000_00F0);
    check("post_flush_miss_3000", {63'd0, l2_valid_o}, 64'd1);
    l2_fill("refill_3000", 32'h3000, 8'hF0);
    load(32'h5024, 4'd14, 32'h0000_0091);
    check("post_flush_miss_5020", {63'd0, l2_valid_o}, 64'd1);
    l2_fill("refill_5020", 32'h5020, 8'h90);

    // reset in FILL_WAIT, late response dropped, next load misses
    exp_q.push_back({4'd15, 32'h0000_0070});
    issue(1'b0, 32'h6000, 32'd0, 4'd0, 4'd15);
    void'(exp_q.pop_back());
    check("rst_fill_req", {63'd0, l2_valid_o}, 64'd1);
    tick();
    check("rst_fill_wait_state", {61'd0, state_dbg_o}, 64'd4);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_fill_reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    l2_valid_i = 1'b1;
    l2_data_i  = make_line(8'h50);
    tick();
    l2_valid_i = 1'b0;
    l2_data_i  = '0;
    check("late_resp_ready", {63'd0, ready_out}, 64'd0);
    check("late_resp_state", {61'd0, state_dbg_o}, 64'd0);
    load(32'h6000, 4'd1, 32'h0000_0070);
    check("after_reset_miss", {63'd0, l2_valid_o}, 64'd1);
    l2_fill("refill_6000", 32'h6000, 8'h70);

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
